// File: rtl/lsu_mem_port.sv
// Load/store unit between execute and a word-only data_mem; sub-word stores become read-modify-write.
// Latency from acceptance edge T: error T+1, load/sw T+2, sb/sh T+3 (resp_valid pulse).
// Backpressure: req_ready only in IDLE; one request in flight, no queueing, inputs ignored while busy.
module lsu_mem_port #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    state_t      state, state_nxt;
    logic        accept;
    logic        f3_illegal, misaligned, out_of_range, req_err;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] word_q;

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept = req_valid && (state == IDLE);

    // Request screening on the live inputs; only meaningful at the acceptance edge.
    always_comb begin
        f3_illegal   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                       || (req_we && req_funct3[2]);
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                       || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr >= ADDR_LIMIT);
        req_err      = f3_illegal || misaligned || out_of_range;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory/handshake outputs; memory strobes are pure state decodes so reset drops them at once.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        mem_wd     = 32'h0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_nxt = RESP;
                    end else if (!req_we) begin
                        state_nxt = READ;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                mem_read  = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                state_nxt = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wd    = (f3_q[1:0] == 2'b10) ? wdata_q : merged;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load lane extraction with sign/zero extension, little-endian.
    always_comb begin
        sel_byte = 8'h0;
        case (addr_q[1:0])
            2'd0: sel_byte = mem_rd[7:0];
            2'd1: sel_byte = mem_rd[15:8];
            2'd2: sel_byte = mem_rd[23:16];
            2'd3: sel_byte = mem_rd[31:24];
            default: sel_byte = 8'h0;
        endcase
        sel_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_val = {24'h0, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_val = {16'h0, sel_half};
            default: load_val = mem_rd;
        endcase
    end

    // Merge store data into the word captured during READ for sb/sh.
    always_comb begin
        merged = word_q;
        if (f3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = word_q;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // Request capture, RMW word capture and the held response data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            word_q     <= 32'h0;
            resp_rdata <= 32'h0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                if (req_err) begin
                    resp_rdata <= 32'h0;
                end
            end
            if (state == READ) begin
                word_q <= mem_rd;
                if (!we_q) begin
                    resp_rdata <= load_val;
                end
            end
            if (state == WRITE) begin
                resp_rdata <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: word memory plant, byte-level reference model, vector table, random traffic.
// Latency: checks resp_valid cycle per request type against the model.
// Backpressure: checks req_ready low while busy and back-to-back acceptance with req_valid held.
module tb_lsu_mem_port;

    localparam int MW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_port #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Word-only data memory plant with combinational read.
    logic [31:0] mem [0:MW-1];
    logic        load_pre;
    assign mem_rd = (mem_addr < 32'(MW * 4)) ? mem[mem_addr[6:2]] : 32'h0;

    always @(posedge clk) begin
        if (load_pre) begin
            for (int i = 0; i < MW; i++) mem[i] <= (i == 4) ? 32'h8899AABB : 32'h0;
        end else if (mem_write && (mem_addr < 32'(MW * 4))) begin
            mem[mem_addr[6:2]] <= mem_wd;
        end
    end

    // Byte-addressed reference memory.
    logic [7:0] ref_mem [0:MW*4-1];

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: what an access should return and how long it should take.
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic err, output logic [31:0] rd,
                              output int lat, output int rdc, output int wrc, output logic [31:0] wdx);
        int size;
        int idx;
        logic [31:0] v;
        logic [31:0] sh;
        err = 1'b0; rd = 32'h0; lat = 1; rdc = 0; wrc = 0; wdx = 32'h0;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2])) err = 1'b1;
        if ((int'(a[1:0]) % size) != 0) err = 1'b1;
        if (a >= 32'(MW * 4)) err = 1'b1;
        if (!err) begin
            idx = int'(a[6:0]);
            if (!we) begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_mem[idx + i]) << (8 * i));
                if (!f3[2] && size < 4) begin
                    if (v[8 * size - 1]) v = v | (32'hFFFFFFFF << (8 * size));
                end
                rd = v; lat = 2; rdc = 1;
            end else begin
                for (int i = 0; i < size; i++) begin
                    sh = wd >> (8 * i);
                    ref_mem[idx + i] = sh[7:0];
                end
                wdx = ref_word(idx / 4);
                if (size == 4) begin
                    lat = 2; wrc = 1;
                end else begin
                    lat = 3; rdc = 1; wrc = 2;
                end
            end
        end
    endtask

    // Drive one request from IDLE and observe it until its response (bounded).
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic err, output logic [31:0] rd,
                           output int lat, output int rdc, output int wrc,
                           output logic [31:0] wdv, output logic ok);
        err = 1'b0; rd = 32'h0; lat = 0; rdc = 0; wrc = 0; wdv = 32'h0; ok = 1'b1;
        @(negedge clk);
        if (!req_ready) ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b0;
            if (mem_read && mem_write) ok = 1'b0;
            if ((mem_read || mem_write) && mem_addr !== {a[31:2], 2'b00}) ok = 1'b0;
            if (!mem_read && !mem_write && (mem_addr !== 32'h0 || mem_wd !== 32'h0)) ok = 1'b0;
            if (mem_read) begin
                if (rdc != 0) ok = 1'b0;
                rdc = c;
            end
            if (mem_write) begin
                if (wrc != 0) ok = 1'b0;
                wrc = c; wdv = mem_wd;
            end
            if (resp_valid) begin
                lat = c; err = resp_error; rd = resp_rdata;
                break;
            end
        end
        @(negedge clk);
        if (!req_ready || resp_valid) ok = 1'b0;
    endtask

    task automatic apply(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic xerr, input logic [31:0] xrd,
                         input int xlat, input int xrdc, input int xwrc, input logic [31:0] xwd);
        logic err, ok;
        logic [31:0] rd, wdv;
        int lat, rdc, wrc;
        run_req(we, f3, a, wd, err, rd, lat, rdc, wrc, wdv, ok);
        chk({nm, "_err"},   32'(err), 32'(xerr));
        chk({nm, "_rdata"}, rd, xrd);
        chk({nm, "_lat"},   32'(lat), 32'(xlat));
        chk({nm, "_rdcyc"}, 32'(rdc), 32'(xrdc));
        chk({nm, "_wrcyc"}, 32'(wrc), 32'(xwrc));
        chk({nm, "_proto"}, 32'(ok), 32'h1);
        if (xwrc != 0) chk({nm, "_wd"}, wdv, xwd);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
        int          rdc;
        int          wrc;
        logic [31:0] xwd;
    } vec_t;

    vec_t tv [18];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e_err, scr_err;
        logic [31:0] e_rd, e_wd, scr_rd, scr_wd;
        int          e_lat, e_rdc, e_wrc, scr_lat, scr_rdc, scr_wrc;
        logic        saw_w, saw_v;
        logic [7:0]  p_resp, p_rdy, p_rd, p_wr;
        logic [31:0] rmw_wd, b2b_rd, pre_word;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          r;

        tv[0]  = '{1'b0, 3'b000, 32'h11, 32'h0,        1'b0, 32'hFFFFFFAA, 2, 1, 0, 32'h0};
        tv[1]  = '{1'b0, 3'b100, 32'h11, 32'h0,        1'b0, 32'h000000AA, 2, 1, 0, 32'h0};
        tv[2]  = '{1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFF8899, 2, 1, 0, 32'h0};
        tv[3]  = '{1'b0, 3'b101, 32'h12, 32'h0,        1'b0, 32'h00008899, 2, 1, 0, 32'h0};
        tv[4]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h8899AABB, 2, 1, 0, 32'h0};
        tv[5]  = '{1'b1, 3'b000, 32'h12, 32'h12345677, 1'b0, 32'h0,        3, 1, 2, 32'h8877AABB};
        tv[6]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h8877AABB, 2, 1, 0, 32'h0};
        tv[7]  = '{1'b1, 3'b001, 32'h11, 32'hFFFF,     1'b1, 32'h0,        1, 0, 0, 32'h0};
        tv[8]  = '{1'b0, 3'b010, 32'h0E, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0};
        tv[9]  = '{1'b0, 3'b010, 32'h80, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0};
        tv[10] = '{1'b1, 3'b100, 32'h10, 32'h55,       1'b1, 32'h0,        1, 0, 0, 32'h0};
        tv[11] = '{1'b1, 3'b010, 32'h7C, 32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1, 32'hDEADBEEF};
        tv[12] = '{1'b0, 3'b010, 32'h7C, 32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h0};
        tv[13] = '{1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0};
        tv[14] = '{1'b1, 3'b001, 32'h22, 32'h1234CAFE, 1'b0, 32'h0,        3, 1, 2, 32'hCAFE0000};
        tv[15] = '{1'b0, 3'b001, 32'h22, 32'h0,        1'b0, 32'hFFFFCAFE, 2, 1, 0, 32'h0};
        tv[16] = '{1'b0, 3'b000, 32'h7F, 32'h0,        1'b0, 32'hFFFFFFDE, 2, 1, 0, 32'h0};
        tv[17] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,  1'b1, 32'h0,        1, 0, 0, 32'h0};

        for (int i = 0; i < MW * 4; i++) ref_mem[i] = 8'h00;
        ref_mem[16] = 8'hBB; ref_mem[17] = 8'hAA; ref_mem[18] = 8'h99; ref_mem[19] = 8'h88;

        rst = 1'b1; load_pre = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; load_pre = 1'b0;
        @(negedge clk);
        chk("rst_ready",     32'(req_ready),  32'h1);
        chk("rst_resp_vld",  32'(resp_valid), 32'h0);
        chk("rst_resp_err",  32'(resp_error), 32'h0);
        chk("rst_rdata",     resp_rdata,      32'h0);
        chk("rst_mem_rw",    {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr",  mem_addr,        32'h0);
        chk("rst_mem_wd",    mem_wd,          32'h0);

        // Directed vectors.
        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), tv[i].we, tv[i].f3, tv[i].a, tv[i].wd,
                  tv[i].err, tv[i].rd, tv[i].lat, tv[i].rdc, tv[i].wrc, tv[i].xwd);
            ref_access(tv[i].we, tv[i].f3, tv[i].a, tv[i].wd,
                       scr_err, scr_rd, scr_lat, scr_rdc, scr_wrc, scr_wd);
        end

        // Reset during the READ of an sb: no write, no response, memory intact.
        pre_word = ref_word(4);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmwrst_in_read", 32'(mem_read), 32'h1);
        rst = 1'b1;
        #1;
        chk("rmwrst_ready_now", 32'(req_ready), 32'h1);
        saw_w = 1'b0; saw_v = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            saw_w |= mem_write; saw_v |= resp_valid;
            if (c == 2) rst = 1'b0;
        end
        chk("rmwrst_no_write", 32'(saw_w), 32'h0);
        chk("rmwrst_no_resp",  32'(saw_v), 32'h0);
        chk("rmwrst_ready",    32'(req_ready), 32'h1);
        chk("rmwrst_mem",      mem[4], pre_word);

        // Back-to-back with req_valid held: lw 0x10 then sb 0x13.
        p_resp = 8'h0; p_rdy = 8'h0; p_rd = 8'h0; p_wr = 8'h0; rmw_wd = 32'h0; b2b_rd = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h13; req_wdata = 32'hA5A5A511;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            p_resp[c] = resp_valid; p_rdy[c] = req_ready; p_rd[c] = mem_read; p_wr[c] = mem_write;
            if (c == 2) b2b_rd = resp_rdata;
            if (c == 5) rmw_wd = mem_wd;
            if (c == 3) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("b2b_resp_pat",  32'(p_resp), 32'h44);
        chk("b2b_ready_pat", 32'(p_rdy),  32'h88);
        chk("b2b_read_pat",  32'(p_rd),   32'h12);
        chk("b2b_write_pat", 32'(p_wr),   32'h20);
        chk("b2b_lw_rdata",  b2b_rd,      32'h8877AABB);
        chk("b2b_sb_wd",     rmw_wd,      32'h1177AABB);
        ref_access(1'b0, 3'b010, 32'h10, 32'h0, scr_err, scr_rd, scr_lat, scr_rdc, scr_wrc, scr_wd);
        ref_access(1'b1, 3'b000, 32'h13, 32'hA5A5A511, scr_err, scr_rd, scr_lat, scr_rdc, scr_wrc, scr_wd);
        chk("b2b_mem", mem[4], 32'h1177AABB);

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 15);
            we = 1'($urandom_range(0, 1));
            if (r < 2) begin
                f3 = 3'($urandom_range(0, 7));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            a = 32'($urandom_range(0, MW * 4 + 15));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            if (r == 15) a = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
            wd = $urandom;
            ref_access(we, f3, a, wd, e_err, e_rd, e_lat, e_rdc, e_wrc, e_wd);
            apply($sformatf("rnd%0d", i), we, f3, a, wd, e_err, e_rd, e_lat, e_rdc, e_wrc, e_wd);
        end

        for (int w = 0; w < MW; w++) chk($sformatf("final_mem%0d", w), mem[w], ref_word(w));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit placed between the core's execute stage and `data_mem`; it is the initiator on the memory's `memRead`/`memWrite`/`addr`/`wd`/`rd` interface. It accepts one RV32I load or store per request over a valid/ready handshake. It performs byte-lane extraction with sign/zero extension for loads. Because the memory is word-only with no byte enables, it implements byte and halfword stores as read-modify-write sequences. It flags misaligned, out-of-range and unsupported accesses without touching memory.

## Interface
- `MEM_WORDS`, default 32: memory depth in 32-bit words. A byte address `>= MEM_WORDS*4` is out of range.
- `clk` in, 1 bit: clock, rising edge.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `req_valid` in, 1 bit: a request is present.
- `req_ready` out, 1 bit: the block accepts a request this cycle. Equal to `state==IDLE`.
- `req_we` in, 1 bit: 1 = store, 0 = load.
- `req_funct3` in, 3 bits: RISC-V funct3.
  - 000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu.
  - bu and hu are legal for loads only.
- `req_addr` in, 32 bits: byte address.
- `req_wdata` in, 32 bits: store data. Bytes are taken from the low lanes.
- `resp_valid` out, 1 bit: one-cycle completion pulse.
- `resp_rdata` out, 32 bits: load result, extended to 32 bits.
- `resp_error` out, 1 bit: the request was rejected. Valid with `resp_valid`.
- `mem_read` out, 1 bit: to `data_mem.memRead`.
- `mem_write` out, 1 bit: to `data_mem.memWrite`.
- `mem_addr` out, 32 bits: to `data_mem.addr`. Always word-aligned (`{a[31:2],2'b00}`).
- `mem_wd` out, 32 bits: to `data_mem.wd`.
- `mem_rd` in, 32 bits: from `data_mem.rd`. Combinational read of `mem_addr`.

## Operation
- **States:** IDLE, READ, WRITE, RESP.
- **Request acceptance:** a request is accepted when `req_valid && req_ready` at a clock edge. At that edge the block latches `we`, `funct3`, `addr` and `wdata`.
- **Error check** (evaluated on the request inputs at acceptance):
  - misaligned: h/hu with `addr[0]`, or w with `addr[1:0]!=0`;
  - out of range: `addr >= MEM_WORDS*4`;
  - illegal funct3: 011, 110, 111, or bu/hu with `we=1`.
- **Transitions out of IDLE on acceptance:**
  - error → RESP with `resp_error=1`;
  - load → READ;
  - sw → WRITE;
  - sb/sh → READ.
- **READ:**
  - Drives `mem_read=1` and `mem_addr`.
  - Registers `mem_rd` into an internal word register at the clock edge.
  - Next state: WRITE for sb/sh, RESP for loads.
- **WRITE:**
  - Drives `mem_write=1`, `mem_addr` and `mem_wd`.
  - `mem_wd` for sw is `wdata`.
  - For sb, `mem_wd` is the captured word with lane `addr[1:0]` replaced by `wdata[7:0]`.
  - For sh, `mem_wd` is the captured word with half `addr[1]` replaced by `wdata[15:0]`.
  - Next state: RESP.
- **RESP:** `resp_valid=1` for exactly one cycle, then IDLE.
- **Load extraction:** little-endian; byte lane n is bits `[8n+7:8n]`.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- **`resp_rdata` contents:**
  - set to 0 for stores and errors;
  - registered, and held until the next RESP.
- **Outputs outside READ/WRITE:** `mem_read`, `mem_write`, `mem_addr` and `mem_wd` are 0.
  - `mem_read` and `mem_write` are never both 1.
- **Request inputs:** ignored while `req_ready=0`. No queueing.

## Timing
- **Reset values:** state IDLE. `req_ready=1`. All other outputs 0, including the internal word register.
- **Latency from the acceptance edge T** (cycle in which `resp_valid=1`):
  - error: T+1;
  - load: T+2;
  - sw: T+2;
  - sb/sh: T+3.
- **Throughput:** `req_ready` is 0 from T+1 until the cycle after RESP. The minimum spacing between acceptances is therefore:
  - error: 2 cycles;
  - load/sw: 3 cycles;
  - sb/sh: 4 cycles.
- **Write timing:** the memory write commits on the clock edge that ends the WRITE cycle. A load issued after a store completes therefore sees the new data.
- **Reset mid-operation:** `rst` forces IDLE immediately and `mem_write` drops combinationally.
  - If `rst` rises before the edge ending WRITE, no write occurs.
  - A partial RMW never writes stale merged data after reset.
  - No `resp_valid` is produced for the aborted request.
- **`req_valid` held high across RESP:** the next request is accepted on the first edge where IDLE is present. That is one cycle after RESP, never during RESP.

## Test plan
- **Loads at 0x11:** preload word 0x10 = 0x8899AABB.
  - lb → `resp_rdata`=0xFFFFFFAA.
  - lbu → 0x000000AA.
  - lh 0x12 → 0xFFFF8899.
  - lhu 0x12 → 0x00008899.
  - Each shows `resp_valid` at T+2.
- **sb with RMW:** same preload; sb 0x12 with `wdata`=0x12345677.
  - READ at T+1, WRITE at T+2 with `mem_wd`=0x8877AABB, `resp_valid` at T+3.
  - A subsequent lw 0x10 returns 0x8877AABB.
- **Errors:** sh 0x11, lw 0x0E, lw 0x80 (`MEM_WORDS`=32), and funct3=100 with `we=1`.
  - Each gives `resp_valid`+`resp_error`=1 at T+1 and `resp_rdata`=0.
  - `mem_read`/`mem_write` stay 0 throughout.
- **sw then lw:** sw 0x7C with 0xDEADBEEF gives `mem_write` at T+1 only, with no `mem_read`. A following lw 0x7C returns 0xDEADBEEF.
- **Reset mid-RMW:** assert `rst` during READ of an sb.
  - No `mem_write` is ever seen and no `resp_valid` is produced.
  - `req_ready`=1 after reset; the memory word is unchanged.
- **Back-to-back:** hold `req_valid`=1 with a lw then a sb.
  - The second request is accepted one cycle after the first response.
  - `req_ready`=0 for T+1..T+2.
  - No request is lost or duplicated.
